// File: rtl/pov_motion_pkg.sv
// pov_motion_pkg: fixed-point geometry, FSM encoding and start values shared
// by the player point-of-view block and the tracer / overlay consumers.
`ifndef POV_MOTION_PKG_MACROS
`define POV_MOTION_PKG_MACROS
// Real <-> fixed conversion, for elaboration-time constants and debug only.
`define POV_REALF(r) (int'((r) * real'(1 << pov_motion_pkg::DEF_QN)))
`define POV_FREAL(f) (real'(f) / real'(1 << pov_motion_pkg::DEF_QN))
`endif

package pov_motion_pkg;

    localparam int DEF_QM = 12;
    localparam int DEF_QN = 12;
    localparam int FX_W   = DEF_QM + DEF_QN;

    // Start pose: position (1.5, 13.5), facing -Y, half-length viewplane on +X.
    localparam logic [FX_W-1:0] START_PX = 24'h001800;
    localparam logic [FX_W-1:0] START_PY = 24'h00D800;
    localparam logic [FX_W-1:0] START_FX = 24'h000000;
    localparam logic [FX_W-1:0] START_FY = 24'hFFF000;
    localparam logic [FX_W-1:0] START_VX = 24'h000800;
    localparam logic [FX_W-1:0] START_VY = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROT_F,
        ST_ROT_V,
        ST_MOVE,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        ROT_HOLD  = 2'd0,
        ROT_RIGHT = 2'd1,
        ROT_LEFT  = 2'd2
    } rot_dir_t;

    // Both or neither rotate button held means no rotation this frame.
    function automatic rot_dir_t rot_dir(input logic rot_r, input logic rot_l);
        if (rot_r && !rot_l) return ROT_RIGHT;
        if (rot_l && !rot_r) return ROT_LEFT;
        return ROT_HOLD;
    endfunction

endpackage

// File: rtl/pov_motion_shift_rotate.sv
// pov_motion_shift_rotate: combinational shift-add rotation of one (x, y)
// vector by roughly 2^-ROT_SHIFT rad. Shared between facing and viewplane.
module pov_motion_shift_rotate
    import pov_motion_pkg::*;
#(
    parameter int W         = FX_W,
    parameter int ROT_SHIFT = 6
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   dir,
    output logic [W-1:0] x_rot,
    output logic [W-1:0] y_rot
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic signed [W-1:0] xr;
    logic signed [W-1:0] yr;

    assign xs = x;
    assign ys = y;

    // Two shears: x by old y, then y by the new x, so the step keeps unit determinant.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        xr = xs;
        yr = ys;
        case (dir)
            ROT_RIGHT: begin
                xr = xs - (ys >>> ROT_SHIFT);
                yr = ys + (xr >>> ROT_SHIFT);
            end
            ROT_LEFT: begin
                xr = xs + (ys >>> ROT_SHIFT);
                yr = ys - (xr >>> ROT_SHIFT);
            end
            default: ;
        endcase
    end

    assign x_rot = xr;
    assign y_rot = yr;

endmodule

// File: rtl/pov_motion.sv
// pov_motion: frame-synchronised player position / facing / viewplane state.
// Each accepted tick either applies a host-loaded vector set or runs
// rotate-facing, rotate-viewplane, move, commit over four cycles.
module pov_motion
    import pov_motion_pkg::*;
#(
    parameter int QM         = DEF_QM,
    parameter int QN         = DEF_QN,
    parameter int WALK_SHIFT = 6,
    parameter int RUN_SHIFT  = 5,
    parameter int ROT_SHIFT  = 6,
    parameter logic [QM+QN-1:0] POS_MAX = (QM+QN)'((16 << QN) - 1),
    parameter logic [QM+QN-1:0] PX0 = (QM+QN)'(START_PX),
    parameter logic [QM+QN-1:0] PY0 = (QM+QN)'(START_PY),
    parameter logic [QM+QN-1:0] FX0 = (QM+QN)'(START_FX),
    parameter logic [QM+QN-1:0] FY0 = (QM+QN)'(START_FY),
    parameter logic [QM+QN-1:0] VX0 = (QM+QN)'(START_VX),
    parameter logic [QM+QN-1:0] VY0 = (QM+QN)'(START_VY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             moveL,
    input  logic             moveR,
    input  logic             moveF,
    input  logic             moveB,
    input  logic             run,
    input  logic             rotL,
    input  logic             rotR,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [QM+QN-1:0] load_px,
    input  logic [QM+QN-1:0] load_py,
    input  logic [QM+QN-1:0] load_fx,
    input  logic [QM+QN-1:0] load_fy,
    input  logic [QM+QN-1:0] load_vx,
    input  logic [QM+QN-1:0] load_vy,
    output logic [QM+QN-1:0] playerX,
    output logic [QM+QN-1:0] playerY,
    output logic [QM+QN-1:0] facingX,
    output logic [QM+QN-1:0] facingY,
    output logic [QM+QN-1:0] vplaneX,
    output logic [QM+QN-1:0] vplaneY,
    output logic             busy,
    output logic             done,
    output logic [7:0]       overruns
);

    localparam int W = QM + QN;

    state_t state;
    state_t next_state;

    // Working copy of the pose while an update is in flight.
    logic signed [W-1:0] wpx, wpy, wfx, wfy, wvx, wvy;
    // Host-loaded set waiting for the next tick.
    logic signed [W-1:0] ppx, ppy, pfx, pfy, pvx, pvy;
    logic                pending;

    // Buttons as sampled at the accepted tick.
    logic     btn_l, btn_r, btn_f, btn_b, btn_run;
    rot_dir_t btn_rot;

    logic [W-1:0]        rot_x_in, rot_y_in, rot_x_out, rot_y_out;
    logic [4:0]          shamt;
    logic signed [W-1:0] f_step_x, f_step_y, s_step_x, s_step_y, dx, dy;
    logic [W:0]          sum_x, sum_y;
    logic [W-1:0]        mv_px, mv_py;

    logic load_fire;
    logic start_load;

    assign load_ready = !pending;
    assign load_fire  = load_valid && !pending;
    assign start_load = (state == ST_IDLE) && tick && pending;
    assign busy       = (state != ST_IDLE);

    // Sign bit of the widened sum catches underflow; otherwise compare to the cap.
    function automatic logic [W-1:0] clamp_pos(input logic [W:0] v);
        if (v[W]) return '0;
        if (v[W-1:0] > POS_MAX) return POS_MAX;
        return v[W-1:0];
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state: a pending load short-circuits straight to COMMIT.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (tick) next_state = pending ? ST_COMMIT : ST_ROT_F;
            ST_ROT_F:  next_state = ST_ROT_V;
            ST_ROT_V:  next_state = ST_MOVE;
            ST_MOVE:   next_state = ST_COMMIT;
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Host load buffer: one set deep, freed when a tick consumes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            ppx <= '0; ppy <= '0; pfx <= '0; pfy <= '0; pvx <= '0; pvy <= '0;
        end else if (load_fire) begin
            pending <= 1'b1;
            ppx <= load_px; ppy <= load_py;
            pfx <= load_fx; pfy <= load_fy;
            pvx <= load_vx; pvy <= load_vy;
        end else if (start_load) begin
            pending <= 1'b0;
        end
    end

    // Rotator input: facing during ROT_F, viewplane during ROT_V.
    always_comb begin
        rot_x_in = wfx;
        rot_y_in = wfy;
        if (state == ST_ROT_V) begin
            rot_x_in = wvx;
            rot_y_in = wvy;
        end
    end

    pov_motion_shift_rotate #(
        .W         (W),
        .ROT_SHIFT (ROT_SHIFT)
    ) u_shift_rotate (
        .x     (rot_x_in),
        .y     (rot_y_in),
        .dir   (btn_rot),
        .x_rot (rot_x_out),
        .y_rot (rot_y_out)
    );

    // Vector-relative move; viewplane is half length so its step uses one shift less.
    always_comb begin
        shamt    = btn_run ? 5'(RUN_SHIFT) : 5'(WALK_SHIFT);
        f_step_x = wfx >>> shamt;
        f_step_y = wfy >>> shamt;
        s_step_x = wvx >>> (shamt - 5'd1);
        s_step_y = wvy >>> (shamt - 5'd1);
        dx = '0;
        dy = '0;
        if (btn_f) begin dx = dx + f_step_x; dy = dy + f_step_y; end
        if (btn_b) begin dx = dx - f_step_x; dy = dy - f_step_y; end
        if (btn_r) begin dx = dx + s_step_x; dy = dy + s_step_y; end
        if (btn_l) begin dx = dx - s_step_x; dy = dy - s_step_y; end
        sum_x = {wpx[W-1], wpx} + {dx[W-1], dx};
        sum_y = {wpy[W-1], wpy} + {dy[W-1], dy};
        mv_px = clamp_pos(sum_x);
        mv_py = clamp_pos(sum_y);
    end

    // Working pose and sampled buttons, advanced one stage per state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wpx <= '0; wpy <= '0; wfx <= '0; wfy <= '0; wvx <= '0; wvy <= '0;
            btn_l <= 1'b0; btn_r <= 1'b0; btn_f <= 1'b0; btn_b <= 1'b0;
            btn_run <= 1'b0;
            btn_rot <= ROT_HOLD;
        end else begin
            case (state)
                ST_IDLE: if (tick) begin
                    if (pending) begin
                        wpx <= ppx; wpy <= ppy; wfx <= pfx;
                        wfy <= pfy; wvx <= pvx; wvy <= pvy;
                    end else begin
                        wpx <= playerX; wpy <= playerY; wfx <= facingX;
                        wfy <= facingY; wvx <= vplaneX; wvy <= vplaneY;
                        btn_l <= moveL; btn_r <= moveR;
                        btn_f <= moveF; btn_b <= moveB;
                        btn_run <= run;
                        btn_rot <= rot_dir(rotR, rotL);
                    end
                end
                ST_ROT_F: begin wfx <= rot_x_out; wfy <= rot_y_out; end
                ST_ROT_V: begin wvx <= rot_x_out; wvy <= rot_y_out; end
                ST_MOVE:  begin wpx <= mv_px;     wpy <= mv_py;     end
                default: ;
            endcase
        end
    end

    // Committed pose and done pulse: outputs move only when leaving COMMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            playerX <= PX0; playerY <= PY0;
            facingX <= FX0; facingY <= FY0;
            vplaneX <= VX0; vplaneY <= VY0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                playerX <= wpx; playerY <= wpy;
                facingX <= wfx; facingY <= wfy;
                vplaneX <= wvx; vplaneY <= wvy;
            end
        end
    end

    // Saturating count of ticks dropped because an update was still running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overruns <= 8'd0;
        else if (tick && busy && (overruns != 8'hFF))
            overruns <= overruns + 8'd1;
    end

endmodule

// File: tb/tb_pov_motion.sv
// tb_pov_motion: directed pose checks plus randomized ticks, loads and
// overruns scored against a frame-level reference model.
module tb_pov_motion;
    import pov_motion_pkg::*;

    localparam int W      = FX_W;
    localparam int ROT    = 6;
    localparam int WALKS  = 6;
    localparam int RUNS   = 5;
    localparam int POSMAX = (16 << DEF_QN) - 1;
    localparam logic [31:0] MASK = 32'((1 << W) - 1);

    typedef int vset_t [6];

    logic clk = 1'b0;
    logic reset, tick, moveL, moveR, moveF, moveB, run, rotL, rotR;
    logic load_valid, load_ready, busy, done;
    logic [W-1:0] load_px, load_py, load_fx, load_fy, load_vx, load_vy;
    logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic [7:0]   overruns;

    always #5 clk = ~clk;

    pov_motion dut (
        .clk (clk), .reset (reset), .tick (tick),
        .moveL (moveL), .moveR (moveR), .moveF (moveF), .moveB (moveB),
        .run (run), .rotL (rotL), .rotR (rotR),
        .load_valid (load_valid), .load_ready (load_ready),
        .load_px (load_px), .load_py (load_py), .load_fx (load_fx),
        .load_fy (load_fy), .load_vx (load_vx), .load_vy (load_vy),
        .playerX (playerX), .playerY (playerY), .facingX (facingX),
        .facingY (facingY), .vplaneX (vplaneX), .vplaneY (vplaneY),
        .busy (busy), .done (done), .overruns (overruns)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference pose, pending load and overrun count.
    int m_px, m_py, m_fx, m_fy, m_vx, m_vy, m_ovr;
    bit m_pend;
    vset_t m_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wrapw(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > POSMAX) return POSMAX;
        return v;
    endfunction

    // d = +1 turns right, -1 turns left; y uses the freshly rotated x.
    task automatic rotate(inout int x, inout int y, input int d);
        x = wrapw(x - d * (y >>> ROT));
        y = wrapw(y + d * (x >>> ROT));
    endtask

    // b = {run, rotR, rotL, moveB, moveF, moveR, moveL}
    task automatic model_motion(input logic [6:0] b);
        int rd, s, fb, rl;
        rd = int'(b[5]) - int'(b[4]);
        if (rd != 0) begin
            rotate(m_fx, m_fy, rd);
            rotate(m_vx, m_vy, rd);
        end
        s  = b[6] ? RUNS : WALKS;
        fb = int'(b[2]) - int'(b[3]);
        rl = int'(b[1]) - int'(b[0]);
        m_px = clampi(m_px + wrapw(fb * (m_fx >>> s) + rl * (m_vx >>> (s - 1))));
        m_py = clampi(m_py + wrapw(fb * (m_fy >>> s) + rl * (m_vy >>> (s - 1))));
    endtask

    task automatic model_reset();
        m_px = int'(START_PX); m_py = int'(START_PY);
        m_fx = wrapw(int'(START_FX)); m_fy = wrapw(int'(START_FY));
        m_vx = wrapw(int'(START_VX)); m_vy = wrapw(int'(START_VY));
        m_ovr = 0; m_pend = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [6:0] b);
        {run, rotR, rotL, moveB, moveF, moveR, moveL} = b;
    endtask

    task automatic drive_load(input vset_t v);
        load_px = W'(v[0]); load_py = W'(v[1]); load_fx = W'(v[2]);
        load_fy = W'(v[3]); load_vx = W'(v[4]); load_vy = W'(v[5]);
    endtask

    task automatic capture(input vset_t v);
        m_pend = 1;
        for (int i = 0; i < 6; i++) m_q[i] = wrapw(v[i]);
    endtask

    task automatic rand_set(output vset_t v);
        v[0] = int'($urandom_range(0, POSMAX));
        v[1] = int'($urandom_range(0, POSMAX));
        for (int i = 2; i < 6; i++) v[i] = int'($urandom_range(0, 8192)) - 4096;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_px"}, 32'(playerX), 32'(m_px) & MASK);
        check({tag, "_py"}, 32'(playerY), 32'(m_py) & MASK);
        check({tag, "_fx"}, 32'(facingX), 32'(m_fx) & MASK);
        check({tag, "_fy"}, 32'(facingY), 32'(m_fy) & MASK);
        check({tag, "_vx"}, 32'(vplaneX), 32'(m_vx) & MASK);
        check({tag, "_vy"}, 32'(vplaneY), 32'(m_vy) & MASK);
        check({tag, "_ovr"}, 32'(overruns), 32'(m_ovr));
        check({tag, "_ready"}, 32'(load_ready), 32'(!m_pend));
    endtask

    task automatic do_reset();
        reset = 0; tick = 0; load_valid = 0;
        set_btn('0);
        repeat (2) cyc();
        reset = 1;
        cyc();
        model_reset();
    endtask

    task automatic do_load(input vset_t v);
        check("load_ready_pre", 32'(load_ready), 32'(!m_pend));
        drive_load(v);
        load_valid = 1;
        cyc();
        load_valid = 0;
        if (!m_pend) capture(v);
    endtask

    // One frame tick; optional same-cycle load, and optional dropped tick / busy load.
    task automatic run_tick(input logic [6:0] b, input bit inject, input bit load_with_tick);
        int lat, exp_lat;
        bit seen, was_pend;
        vset_t v;
        was_pend = m_pend;
        set_btn(b);
        tick = 1;
        if (load_with_tick && !was_pend) begin
            rand_set(v);
            drive_load(v);
            load_valid = 1;
        end
        cyc();
        tick = 0;
        load_valid = 0;
        set_btn(7'($urandom));
        check("busy_after_tick", 32'(busy), 32'd1);
        if (was_pend) begin
            m_px = m_q[0]; m_py = m_q[1]; m_fx = m_q[2];
            m_fy = m_q[3]; m_vx = m_q[4]; m_vy = m_q[5];
            m_pend = 0;
            exp_lat = 1;
        end else begin
            model_motion(b);
            exp_lat = 4;
            if (load_with_tick) capture(v);
        end
        lat = 0;
        seen = 0;
        while (!seen && lat < 12) begin
            cyc();
            lat++;
            tick = 0;
            load_valid = 0;
            if (done) seen = 1;
            else if (inject && exp_lat == 4) begin
                if (lat == 1 && $urandom_range(0, 1) == 0) begin
                    tick = 1;
                    if (m_ovr < 255) m_ovr++;
                end
                if (lat == 2 && !m_pend && $urandom_range(0, 1) == 0) begin
                    rand_set(v);
                    drive_load(v);
                    load_valid = 1;
                    capture(v);
                end
            end
        end
        check("done_latency", 32'(lat), 32'(exp_lat));
        check_state("tick");
        cyc();
        check("done_width", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vset_t v;
        load_px = '0; load_py = '0; load_fx = '0;
        load_fy = '0; load_vx = '0; load_vy = '0;
        do_reset();

        // Reset defaults.
        check("rst_px", 32'(playerX), 32'h001800);
        check("rst_py", 32'(playerY), 32'h00D800);
        check("rst_fx", 32'(facingX), 32'h000000);
        check("rst_fy", 32'(facingY), 32'hFFF000);
        check("rst_vx", 32'(vplaneX), 32'h000800);
        check("rst_vy", 32'(vplaneY), 32'h000000);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_ovr", 32'(overruns), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Walk and run forward from the start pose.
        run_tick(7'b0000100, 0, 0);
        check("walk_py", 32'(playerY), 32'h00D7C0);
        do_reset();
        run_tick(7'b1000100, 0, 0);
        check("run_py", 32'(playerY), 32'h00D780);

        // One right-rotation step.
        do_reset();
        run_tick(7'b0100000, 0, 0);
        check("rot_fx", 32'(facingX), 32'h000040);
        check("rot_fy", 32'(facingY), 32'hFFF001);
        check("rot_vx", 32'(vplaneX), 32'h000800);
        check("rot_vy", 32'(vplaneY), 32'h000020);

        // Clamp at both ends of the X range.
        do_reset();
        v = '{16, 'h8000, 0, -4096, 'h800, 0};
        do_load(v);
        run_tick(7'b0000000, 0, 0);
        run_tick(7'b0000001, 0, 0);
        check("clamp_lo_px", 32'(playerX), 32'h000000);
        v = '{POSMAX - 16, 'h8000, 0, -4096, 'h800, 0};
        do_load(v);
        run_tick(7'b0000000, 0, 0);
        run_tick(7'b0000010, 0, 0);
        check("clamp_hi_px", 32'(playerX), 32'(POSMAX));

        // Load handshake; a second offer while pending must be refused.
        v = '{'h5000, 'h6000, 'h100, -'h200, 'h300, 'h40};
        do_load(v);
        check("ready_dropped", 32'(load_ready), 32'd0);
        v = '{'h1111, 'h2222, 1, 2, 3, 4};
        do_load(v);
        run_tick(7'b0010101, 0, 0);
        check("load_px", 32'(playerX), 32'h005000);
        check("load_vy", 32'(vplaneY), 32'h000040);
        check("ready_back", 32'(load_ready), 32'd1);

        // Two ticks two cycles apart: second one is dropped.
        do_reset();
        tick = 1; cyc(); tick = 0; cyc(); tick = 1; cyc(); tick = 0;
        lat = 0;
        while (!done && lat < 12) begin cyc(); lat++; end
        check("ovr_done_seen", 32'(done), 32'd1);
        m_ovr = 1;
        model_motion(7'b0000000);
        check_state("ovr");
        cyc();

        // Reset at E2 of an update, with a load accepted while busy.
        run_tick(7'b0000100, 0, 0);
        set_btn(7'b0000100);
        tick = 1; cyc(); tick = 0;
        v = '{'h7000, 'h7000, 5, 6, 7, 8};
        drive_load(v);
        load_valid = 1; cyc(); load_valid = 0;
        cyc();
        reset = 0;
        #1;
        check("mid_rst_px", 32'(playerX), 32'h001800);
        check("mid_rst_py", 32'(playerY), 32'h00D800);
        check("mid_rst_fy", 32'(facingY), 32'hFFF000);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(load_ready), 32'd1);
        cyc();
        reset = 1;
        cyc();
        model_reset();
        run_tick(7'b0000000, 0, 0);

        // Overrun saturation: tick held high long enough to drop >255 ticks.
        do_reset();
        tick = 1;
        repeat (400) cyc();
        tick = 0;
        lat = 0;
        while (busy && lat < 12) begin cyc(); lat++; end
        check("sat_idle", 32'(busy), 32'd0);
        m_ovr = 255;
        check_state("sat");

        // Randomized frames against the model.
        do_reset();
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_set(v);
                do_load(v);
            end
            run_tick(7'($urandom), 1, $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
